// File: rtl/entity_line_scanner.sv
// Per-scanline entity culler: walks the entity table on line_start and queues visible entities.
// Optional feature macro ENT_SCAN_DROP_CNT_EN adds a saturating drop_count output.

module entity_line_scanner #(
    parameter int ADDR_W   = 8,
    parameter int ENT_SIZE = 48,
    parameter int MAX_HITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [8:0]        line_num,
    input  logic [ADDR_W-1:0] entities_number,
    output logic [ADDR_W-1:0] address_read_ent,
    input  logic [20:0]       data_read_ent,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [2:0]        hit_type,
    output logic [8:0]        hit_col,
    output logic [5:0]        hit_yoff,
    output logic              scan_busy,
    output logic              scan_done,
`ifdef ENT_SCAN_DROP_CNT_EN
    output logic [ADDR_W-1:0] drop_count,
`endif
    output logic              hit_overflow
);

    localparam int PTR_W = $clog2(MAX_HITS);
    localparam int CNT_W = PTR_W + 1;
    localparam int HIT_W = 18;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [8:0]        r_line;
    logic [ADDR_W-1:0] r_num;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic              r_done;
    logic              w_last;
    logic [9:0]        w_diff;
    logic              w_hit;
    logic [HIT_W-1:0]  w_hit_data;

    logic [HIT_W-1:0]  r_mem [MAX_HITS];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_hvalid;
    logic [HIT_W-1:0]  r_head;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic              w_drop;
    logic [CNT_W-1:0]  w_cnt_kept;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [PTR_W-1:0]  w_rd_next;
    logic [HIT_W-1:0]  w_head_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_last       = (r_addr == r_num - ADDR_W'(1));
        w_state_next = r_state;
        if (line_start) begin
            w_state_next = (entities_number != '0) ? S_SCAN : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_SCAN:  if (w_last) w_state_next = S_FLUSH;
                S_FLUSH: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        scan_busy        = (r_state != S_IDLE);
        scan_done        = r_done;
        address_read_ent = r_addr;
    end

    // r_pend marks that data_read_ent holds the entry addressed during the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
            r_num  <= '0;
            r_addr <= '0;
            r_pend <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_pend <= (r_state == S_SCAN) && !line_start;
            r_done <= 1'b0;
            if (line_start) begin
                r_line <= line_num;
                r_num  <= entities_number;
                r_addr <= '0;
                r_done <= (entities_number == '0);
            end else begin
                case (r_state)
                    S_SCAN:  if (!w_last) r_addr <= r_addr + ADDR_W'(1);
                    S_FLUSH: r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Unsigned 10-bit difference: a row below the line sets bit 9 and can never hit.
    always_comb begin
        w_diff     = {1'b0, r_line} - {1'b0, data_read_ent[17:9]};
        w_hit      = r_pend && !w_diff[9] && (w_diff < 10'(ENT_SIZE));
        w_hit_data = {data_read_ent[20:18], data_read_ent[8:0], w_diff[5:0]};
    end

    // Head register is loaded with whatever entry will be at the front after this edge.
    always_comb begin
        w_pop       = r_hvalid && hit_ready;
        w_full      = (r_cnt == CNT_W'(MAX_HITS));
        w_push_ok   = w_hit && (!w_full || w_pop);
        w_drop      = w_hit && w_full && !w_pop;
        w_cnt_kept  = r_cnt - CNT_W'(w_pop);
        w_cnt_next  = w_cnt_kept + CNT_W'(w_push_ok);
        w_rd_next   = r_rd + PTR_W'(w_pop);
        w_head_next = (w_cnt_kept == '0) ? w_hit_data : r_mem[w_rd_next];
    end

    always_ff @(posedge clk) begin
        if (!rst && !line_start && w_push_ok) begin
            r_mem[r_wr] <= w_hit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_hvalid <= 1'b0;
            r_head   <= '0;
        end else if (line_start) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_hvalid <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + PTR_W'(1);
            r_rd     <= w_rd_next;
            r_cnt    <= w_cnt_next;
            r_hvalid <= (w_cnt_next != '0);
            if (w_cnt_next != '0) r_head <= w_head_next;
        end
    end

    always_comb begin
        hit_valid                     = r_hvalid;
        {hit_type, hit_col, hit_yoff} = r_head;
    end

`ifdef ENT_SCAN_DROP_CNT_EN
    logic [ADDR_W-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst || line_start) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        drop_count   = r_drop_cnt;
        hit_overflow = (r_drop_cnt != '0);
    end
`else
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst || line_start) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_comb begin
        hit_overflow = r_overflow;
    end
`endif

endmodule

// File: tb/tb_entity_line_scanner.sv
// Self-checking bench for entity_line_scanner: directed scenarios plus randomized tables
// checked against a list-based culling model.
`timescale 1ns/1ps

module tb_entity_line_scanner;

    localparam int ADDR_W   = 8;
    localparam int ENT_SIZE = 48;
    localparam int MAX_HITS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_start;
    logic [8:0]        line_num;
    logic [ADDR_W-1:0] entities_number;
    logic [ADDR_W-1:0] address_read_ent;
    logic [20:0]       data_read_ent;
    logic              hit_valid;
    logic              hit_ready;
    logic [2:0]        hit_type;
    logic [8:0]        hit_col;
    logic [5:0]        hit_yoff;
    logic              scan_busy;
    logic              scan_done;
    logic              hit_overflow;
`ifdef ENT_SCAN_DROP_CNT_EN
    logic [ADDR_W-1:0] drop_count;
`endif

    entity_line_scanner #(
        .ADDR_W   (ADDR_W),
        .ENT_SIZE (ENT_SIZE),
        .MAX_HITS (MAX_HITS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .line_start       (line_start),
        .line_num         (line_num),
        .entities_number  (entities_number),
        .address_read_ent (address_read_ent),
        .data_read_ent    (data_read_ent),
        .hit_valid        (hit_valid),
        .hit_ready        (hit_ready),
        .hit_type         (hit_type),
        .hit_col          (hit_col),
        .hit_yoff         (hit_yoff),
        .scan_busy        (scan_busy),
        .scan_done        (scan_done),
`ifdef ENT_SCAN_DROP_CNT_EN
        .drop_count       (drop_count),
`endif
        .hit_overflow     (hit_overflow)
    );

    always #5 clk = ~clk;

    // Entity table with registered, 1-cycle read latency.
    logic [20:0] tbl [256];
    always @(posedge clk) data_read_ent <= tbl[address_read_ent];

    logic [17:0] got [$];
    logic [17:0] exp_q [$];
    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst && hit_valid && hit_ready) got.push_back({hit_type, hit_col, hit_yoff});
        if (scan_done) done_cnt++;
        if (scan_busy) busy_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    // Visible iff the line lies in [row, row+ENT_SIZE-1]; yoff is the distance from the row.
    task automatic model_scan(input int L, input int upto);
        int row;
        for (int i = 0; i < upto; i++) begin
            row = int'(tbl[i][17:9]);
            if (L >= row && L - row < ENT_SIZE)
                exp_q.push_back({tbl[i][20:18], tbl[i][8:0], 6'(L - row)});
        end
    endtask

    task automatic fill_grid();
        for (int i = 0; i < 256; i++) tbl[i] = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                tbl[r*10 + c] = {3'd4, 9'(r*48), 9'(c*48)};
    endtask

    task automatic start_line(input int L, input int N);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_num = 9'(L);
        entities_number = ADDR_W'(N);
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    // Returns the cycle index (line_start cycle = 0) in which scan_done is seen; 0 if never.
    task automatic run_until_done(input int limit, output int cyc);
        cyc = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (scan_done) begin
                cyc = k;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic drain();
        repeat (MAX_HITS + 8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; line_start = 1'b0; line_num = '0; entities_number = '0; hit_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (address_read_ent !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", address_read_ent); end
        n_tests++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", hit_valid); end
        n_tests++; if ({hit_type, hit_col, hit_yoff} !== 18'd0) begin n_fail++; $display("FAIL reset_head: got %h expected 0", {hit_type, hit_col, hit_yoff}); end
        n_tests++; if ({scan_busy, scan_done, hit_overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {scan_busy, scan_done, hit_overflow}); end
`ifdef ENT_SCAN_DROP_CNT_EN
        n_tests++; if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_grid(input string name, input int L);
        int base, cyc, b0;
        fill_grid();
        hit_ready = 1'b1;
        exp_q.delete();
        model_scan(L, 100);
        base = got.size();
        b0 = busy_cnt;
        start_line(L, 100);
        run_until_done(300, cyc);
        n_tests++; if (cyc != 102) begin n_fail++; $display("FAIL %s done_cycle: got %0d expected 102", name, cyc); end
        drain();
        n_tests++; if (busy_cnt - b0 != 101) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected 101", name, busy_cnt - b0); end
        n_tests++; if (hit_overflow !== 1'b0) begin n_fail++; $display("FAIL %s overflow: got %b expected 0", name, hit_overflow); end
        n_tests++; if (got.size() - base != exp_q.size()) begin n_fail++; $display("FAIL %s hit_count: got %0d expected %0d", name, got.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            n_tests++; if (got[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL %s hit[%0d]: got %h expected %h", name, i, got[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_boundaries();
        int base, cyc;
        logic [20:0] ents [4];
        int lines [2];
        lines[0] = 0;
        lines[1] = 100;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 256; i++) tbl[i] = '0;
            if (t == 0) begin
                ents[0] = {3'd1, 9'd1, 9'd5};     // row just below line 0: must not wrap
                ents[1] = {3'd2, 9'd0, 9'd6};
                ents[2] = {3'd3, 9'd511, 9'd7};
                ents[3] = {3'd5, 9'd464, 9'd8};
            end else begin
                ents[0] = {3'd1, 9'd53, 9'd11};   // offset 47: last covered line
                ents[1] = {3'd2, 9'd52, 9'd12};   // offset 48: just outside
                ents[2] = {3'd3, 9'd100, 9'd13};
                ents[3] = {3'd6, 9'd101, 9'd14};
            end
            for (int i = 0; i < 4; i++) tbl[i] = ents[i];
            hit_ready = 1'b1;
            exp_q.delete();
            model_scan(lines[t], 4);
            base = got.size();
            start_line(lines[t], 4);
            run_until_done(50, cyc);
            n_tests++; if (cyc != 6) begin n_fail++; $display("FAIL boundary%0d done_cycle: got %0d expected 6", t, cyc); end
            drain();
            n_tests++; if (got.size() - base != exp_q.size()) begin n_fail++; $display("FAIL boundary%0d hit_count: got %0d expected %0d", t, got.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
                n_tests++; if (got[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL boundary%0d hit[%0d]: got %h expected %h", t, i, got[base+i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        int base, cyc, L, N;
        for (int it = 0; it < 8; it++) begin
            L = $urandom_range(0, 511);
            N = $urandom_range(1, 60);
            for (int i = 0; i < 256; i++) tbl[i] = '0;
            for (int i = 0; i < N; i++)
                tbl[i] = {3'($urandom), 9'(L - int'($urandom_range(0, 70))), 9'($urandom)};
            hit_ready = 1'b1;
            exp_q.delete();
            model_scan(L, N);
            base = got.size();
            start_line(L, N);
            run_until_done(200, cyc);
            n_tests++; if (cyc != N + 2) begin n_fail++; $display("FAIL rand%0d done_cycle: got %0d expected %0d", it, cyc, N + 2); end
            drain();
            n_tests++; if (got.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rand%0d hit_count: got %0d expected %0d", it, got.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
                n_tests++; if (got[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d hit[%0d]: got %h expected %h", it, i, got[base+i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, cyc;
        fill_grid();
        hit_ready = 1'b0;
        exp_q.delete();
        model_scan(50, 100);
        base = got.size();
        start_line(50, 100);
        run_until_done(300, cyc);
        n_tests++; if (cyc != 102) begin n_fail++; $display("FAIL bp done_cycle: got %0d expected 102", cyc); end
        n_tests++; if (hit_overflow !== 1'b1) begin n_fail++; $display("FAIL bp overflow: got %b expected 1", hit_overflow); end
        n_tests++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL bp valid: got %b expected 1", hit_valid); end
        n_tests++; if ({hit_type, hit_col, hit_yoff} !== exp_q[0]) begin n_fail++; $display("FAIL bp head: got %h expected %h", {hit_type, hit_col, hit_yoff}, exp_q[0]); end
`ifdef ENT_SCAN_DROP_CNT_EN
        n_tests++; if (int'(drop_count) != exp_q.size() - MAX_HITS) begin n_fail++; $display("FAIL bp drop_count: got %0d expected %0d", drop_count, exp_q.size() - MAX_HITS); end
`endif
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            hit_ready = 1'($urandom_range(0, 1));
        end
        hit_ready = 1'b1;
        drain();
        n_tests++; if (hit_overflow !== 1'b1) begin n_fail++; $display("FAIL bp overflow_sticky: got %b expected 1", hit_overflow); end
        n_tests++; if (got.size() - base != MAX_HITS) begin n_fail++; $display("FAIL bp pop_count: got %0d expected %0d", got.size() - base, MAX_HITS); end
        for (int i = 0; i < MAX_HITS && base + i < got.size(); i++) begin
            n_tests++; if (got[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL bp pop[%0d]: got %h expected %h", i, got[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        int base, cyc, d0;
        fill_grid();
        hit_ready = 1'b1;
        exp_q.delete();
        model_scan(50, 18);     // entries pushed before the abort edge 20 cycles in
        model_scan(100, 100);
        base = got.size();
        d0 = done_cnt;
        start_line(50, 100);
        repeat (18) @(posedge clk);
        start_line(100, 100);
        run_until_done(300, cyc);
        n_tests++; if (cyc != 102) begin n_fail++; $display("FAIL abort done_cycle: got %0d expected 102", cyc); end
        drain();
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL abort done_pulses: got %0d expected 1", done_cnt - d0); end
        n_tests++; if (got.size() - base != exp_q.size()) begin n_fail++; $display("FAIL abort hit_count: got %0d expected %0d", got.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            n_tests++; if (got[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL abort hit[%0d]: got %h expected %h", i, got[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_scan();
        int base, cyc, d0, b0;
        fill_grid();
        hit_ready = 1'b1;
        base = got.size();
        d0 = done_cnt;
        b0 = busy_cnt;
        start_line(50, 0);
        run_until_done(10, cyc);
        n_tests++; if (cyc != 1) begin n_fail++; $display("FAIL n0 done_cycle: got %0d expected 1", cyc); end
        drain();
        n_tests++; if (busy_cnt - b0 != 0) begin n_fail++; $display("FAIL n0 busy_cycles: got %0d expected 0", busy_cnt - b0); end
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL n0 done_pulses: got %0d expected 1", done_cnt - d0); end
        n_tests++; if (got.size() - base != 0) begin n_fail++; $display("FAIL n0 hit_count: got %0d expected 0", got.size() - base); end
    endtask

    task automatic test_midscan_reset();
        int base, cyc;
        fill_grid();
        hit_ready = 1'b0;
        start_line(50, 100);
        repeat (14) @(posedge clk);
        @(negedge clk);
        n_tests++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre valid: got %b expected 1", hit_valid); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (address_read_ent !== '0) begin n_fail++; $display("FAIL rst_mid addr: got %0d expected 0", address_read_ent); end
        n_tests++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid: got %b expected 0", hit_valid); end
        n_tests++; if ({hit_type, hit_col, hit_yoff} !== 18'd0) begin n_fail++; $display("FAIL rst_mid head: got %h expected 0", {hit_type, hit_col, hit_yoff}); end
        n_tests++; if ({scan_busy, scan_done, hit_overflow} !== 3'b000) begin n_fail++; $display("FAIL rst_mid flags: got %b expected 000", {scan_busy, scan_done, hit_overflow}); end
        @(posedge clk); #1;
        rst = 1'b0;
        hit_ready = 1'b1;
        exp_q.delete();
        model_scan(50, 100);
        base = got.size();
        start_line(50, 100);
        run_until_done(300, cyc);
        n_tests++; if (cyc != 102) begin n_fail++; $display("FAIL rst_after done_cycle: got %0d expected 102", cyc); end
        drain();
        n_tests++; if (got.size() - base != exp_q.size()) begin n_fail++; $display("FAIL rst_after hit_count: got %0d expected %0d", got.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++) begin
            n_tests++; if (got[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_after hit[%0d]: got %h expected %h", i, got[base+i], exp_q[i]); end
        end
    endtask

    initial begin
        fill_grid();
        test_reset();
        test_grid("grid_l50", 50);
        test_grid("grid_l480", 480);
        test_grid("grid_l47", 47);
        test_boundaries();
        test_random();
        test_backpressure();
        test_abort();
        test_empty_scan();
        test_midscan_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
